// File: rtl/vram_pkg.sv
// vram_pkg: shared framebuffer geometry, pixel, rectangle command and FSM types
package vram_pkg;
  localparam int FB_W = 320;
  localparam int FB_H = 240;
  typedef logic [7:0] rgb332_t;
  typedef struct packed {
    logic [8:0] x0;
    logic [7:0] y0;
    logic [8:0] w;
    logic [7:0] h;
    rgb332_t    color;
  } rect_cmd_t;
  typedef enum logic [1:0] {S_IDLE, S_CLIP, S_WRITE, S_DONE} state_t;
endpackage

// File: rtl/rect_clip.sv
// rect_clip: clip a rectangle to the framebuffer and flag rectangles with no visible pixels
module rect_clip
  import vram_pkg::*;
#(
  parameter int FB_W = vram_pkg::FB_W,
  parameter int FB_H = vram_pkg::FB_H
) (
  input  logic [8:0] x0,
  input  logic [7:0] y0,
  input  logic [8:0] w,
  input  logic [7:0] h,
  output logic [8:0] x_end,
  output logic [7:0] y_end,
  output logic       empty
);
  localparam logic [9:0] X_MAX = 10'(FB_W);
  localparam logic [8:0] Y_MAX = 9'(FB_H);
  logic [9:0] x_sum;
  logic [8:0] y_sum;
  always_comb begin
    x_sum = {1'b0, x0} + {1'b0, w};
    y_sum = {1'b0, y0} + {1'b0, h};
    x_end = x_sum > X_MAX ? X_MAX[8:0] : x_sum[8:0];
    y_end = y_sum > Y_MAX ? Y_MAX[7:0] : y_sum[7:0];
    empty = w == '0 || h == '0 || {1'b0, x0} >= X_MAX || {1'b0, y0} >= Y_MAX;
  end
endmodule

// File: rtl/vram_rect_writer.sv
// vram_rect_writer: fills clipped rectangles in VRAM, one granted pixel write per cycle
module vram_rect_writer #(
  parameter int ADDR_W = 17,
  parameter int FB_W   = vram_pkg::FB_W,
  parameter int FB_H   = vram_pkg::FB_H
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [8:0]        CMD_X0,
  input  logic [7:0]        CMD_Y0,
  input  logic [8:0]        CMD_W,
  input  logic [7:0]        CMD_H,
  input  logic [7:0]        CMD_COLOR,
  output logic              VRAM_WE,
  output logic [ADDR_W-1:0] VRAM_WADDR,
  output logic [7:0]        VRAM_WDATA,
  input  logic              VRAM_WGNT,
  output logic              BUSY,
  output logic              DONE
);
  import vram_pkg::*;
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(FB_W);
  state_t            state;
  rect_cmd_t         cmd;
  logic [ADDR_W-1:0] base, row_base, clip_row_base;
  logic [8:0]        x, x_end, clip_x_end;
  logic [7:0]        y, y_end, clip_y_end;
  logic              clip_empty;
  rect_clip #(.FB_W(FB_W), .FB_H(FB_H)) u_clip (
    .x0(cmd.x0), .y0(cmd.y0), .w(cmd.w), .h(cmd.h),
    .x_end(clip_x_end), .y_end(clip_y_end), .empty(clip_empty)
  );
  // y0*320 as shift-add so no multiplier is inferred
  assign clip_row_base = base + ADDR_W'({cmd.y0, 8'b0}) + ADDR_W'({cmd.y0, 6'b0});
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      CMD_READY  <= 1'b1;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      VRAM_WE    <= 1'b0;
      VRAM_WADDR <= '0;
      VRAM_WDATA <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (CMD_VALID && CMD_READY) begin
          cmd       <= '{CMD_X0, CMD_Y0, CMD_W, CMD_H, CMD_COLOR};
          base      <= BASE_ADDR;
          CMD_READY <= 1'b0;
          BUSY      <= 1'b1;
          state     <= S_CLIP;
        end
        S_CLIP: begin
          x_end    <= clip_x_end;
          y_end    <= clip_y_end;
          x        <= cmd.x0;
          y        <= cmd.y0;
          row_base <= clip_row_base;
          if (clip_empty) begin
            DONE  <= 1'b1;
            state <= S_DONE;
          end else begin
            VRAM_WE    <= 1'b1;
            VRAM_WADDR <= clip_row_base + ADDR_W'(cmd.x0);
            VRAM_WDATA <= cmd.color;
            state      <= S_WRITE;
          end
        end
        S_WRITE: if (VRAM_WGNT) begin
          if (x != x_end - 9'd1) begin
            x          <= x + 9'd1;
            VRAM_WADDR <= row_base + ADDR_W'(x + 9'd1);
          end else if (y != y_end - 8'd1) begin
            x          <= cmd.x0;
            y          <= y + 8'd1;
            row_base   <= row_base + STRIDE;
            VRAM_WADDR <= row_base + STRIDE + ADDR_W'(cmd.x0);
          end else begin
            VRAM_WE <= 1'b0;
            DONE    <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          DONE      <= 1'b0;
          BUSY      <= 1'b0;
          CMD_READY <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/vram_rect_writer.md
Name: vram_rect_writer

Overview:
- Write-side engine for the display VRAM. Scanout reads this memory, and this block fills it.
- Accepts rectangle-fill commands and writes one 8-bit pixel per granted cycle.
- Framebuffer is 320x240 at BASE_ADDR, pixel address = BASE_ADDR + y*320 + x, taken mod 2^ADDR_W.
- Sits between the command source (CPU/GPU command decoder) and the VRAM write port arbiter. Rectangles are clipped to the screen.

Parameters:
- ADDR_W, 17: VRAM address width. All address arithmetic wraps mod 2^ADDR_W.
- FB_W, 320: framebuffer width in pixels. Row stride is FB_W.
- FB_H, 240: framebuffer height in pixels.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- BASE_ADDR  in  ADDR_W  framebuffer base. Sampled at command accept.
- CMD_VALID  in  1  command valid.
- CMD_READY  out  1  command ready. High only in IDLE.
- CMD_X0  in  9  left x.
- CMD_Y0  in  8  top y.
- CMD_W  in  9  width in pixels.
- CMD_H  in  8  height in pixels.
- CMD_COLOR  in  8  RGB332 fill value.
- VRAM_WE  out  1  write request.
- VRAM_WADDR  out  ADDR_W  write address.
- VRAM_WDATA  out  8  write data.
- VRAM_WGNT  in  1  arbiter grant. A write completes in a cycle where VRAM_WE and VRAM_WGNT are both high.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse at command completion.

Behaviour:
- Reset: state=IDLE, CMD_READY=1, VRAM_WE=0, VRAM_WADDR=0, VRAM_WDATA=0, BUSY=0, DONE=0. RST mid-fill aborts immediately: no further writes and no DONE pulse.
- FSM states: IDLE, CLIP, WRITE, DONE.
- IDLE:
  - Accept when CMD_VALID & CMD_READY at edge t.
  - Latch x0, y0, w, h, color and BASE_ADDR.
  - Go to CLIP.
- CLIP (cycle t+1):
  - Compute x_end = min(x0+w, FB_W) using a 10-bit sum, and y_end = min(y0+h, FB_H) using a 9-bit sum.
  - Compute row_base = BASE + y0*FB_W, with the multiply as (y0<<8)+(y0<<6).
  - Empty rectangle (w==0, h==0, x0>=FB_W or y0>=FB_H): go to DONE. DONE is high in cycle t+2 and no write is issued.
  - Otherwise set x=x0, y=y0 and go to WRITE.
- WRITE:
  - VRAM_WE=1, VRAM_WADDR=row_base+x, VRAM_WDATA=color. All three are registered and change only on a granted cycle.
  - First VRAM_WE is high in cycle t+2.
  - While VRAM_WGNT is low, hold address and data stable and keep WE high.
  - On grant with x < x_end-1: x++.
  - On grant with x == x_end-1 and y < y_end-1: x=x0, y++, row_base += FB_W.
  - On grant of the last pixel: VRAM_WE=0 next cycle, go to DONE.
  - Raster order is x-major, ascending. Unstalled throughput is 1 pixel/cycle, i.e. w'*h' WE cycles for the clipped size.
- DONE: DONE=1 for exactly one cycle, then IDLE. CMD_READY returns high the cycle after DONE.
- No command queueing. CMD_VALID outside IDLE is ignored, and the source holds it.
- A BASE_ADDR change during a fill has no effect until the next command.

Decomposition:
- Shared package vram_pkg:
  - FB_W, FB_H constants.
  - RGB332 pixel typedef.
  - Rectangle command struct {x0, y0, w, h, color}.
  - FSM state encoding.
- Sub-module rect_clip: combinational clipping plus empty detection, reusable by future copy/blit engines.
- FSM, raster counters and address stepping stay in the top.

Test Plan:
- Basic fill: BASE=0, (x0=10, y0=20, w=3, h=2, color=0xE0), WGNT=1 → WADDR 6410, 6411, 6412, 6730, 6731, 6732, all with WDATA=0xE0. First WE at t+2, DONE pulse one cycle after the last write, 6 WE cycles total.
- Clipping: (x0=318, y0=239, w=5, h=4) → exactly 2 writes, 76798 and 76799, then DONE.
- Empty rectangle: w=0 (then separately x0=320) → no WE at all, DONE high at t+2, CMD_READY high at t+3.
- Grant stall: same as basic fill, with WGNT low for 3 cycles during pixel 6411 → WADDR/WDATA held at 6411 throughout. The sequence is otherwise unchanged, with 6 granted writes.
- Address wrap: BASE=0x1FFFF, (0, 0, 2, 1) → writes 0x1FFFF then 0x00000.
- Reset mid-fill: (0, 0, 100, 10) with RST asserted after 50 writes → VRAM_WE=0 the next cycle. No DONE, CMD_READY=1, and a new command is accepted normally afterwards.
